apb_bridge_ctrl: RTL

APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

---
 rtl/bridge_pkg.sv | 34 +++
 rtl/apb_bridge_ctrl_if.sv | 33 +++
 rtl/apb_bridge_decode.sv | 27 ++
 rtl/apb_bridge_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// ST_ERR1/ST_ERR2 exist only when BRIDGE_ERR_RESP_EN is defined.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3
`ifdef BRIDGE_ERR_RESP_EN
        ,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
`endif
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;
    localparam logic [31:0] SLV3_BASE  = 32'h8C00_0000;
    localparam logic [31:0] SLV3_LIMIT = 32'h8FFF_FFFF;

endpackage

// File: rtl/apb_bridge_ctrl_if.sv
// AHB-side and APB-side signal bundle of the bridge.
// slave = bridge view, master = AHB master / APB slave environment.
interface apb_bridge_ctrl_if;

    logic [1:0]  htrans;
    logic        hwrite;
    logic        hreadyin;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [3:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport slave (
        input  htrans, hwrite, hreadyin, hsize, haddr, hwdata, prdata,
        output hreadyout, hresp, hrdata,
        output pselx, penable, pwrite, paddr, pwdata
    );

    modport master (
        output htrans, hwrite, hreadyin, hsize, haddr, hwdata, prdata,
        input  hreadyout, hresp, hrdata,
        input  pselx, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_bridge_decode.sv
// Address decode: four 64 MB APB windows, one-hot select.
module apb_bridge_decode
    import bridge_pkg::*;
(
    input  logic [31:0] i_haddr,
    output logic [3:0]  o_select,
    output logic        o_unmapped
);

    always_comb begin
        o_select = 4'b0000;
        unique case (1'b1)
            (i_haddr >= SLV0_BASE && i_haddr <= SLV0_LIMIT):
                o_select = 4'b0001;
            (i_haddr >= SLV1_BASE && i_haddr <= SLV1_LIMIT):
                o_select = 4'b0010;
            (i_haddr >= SLV2_BASE && i_haddr <= SLV2_LIMIT):
                o_select = 4'b0100;
            (i_haddr >= SLV3_BASE && i_haddr <= SLV3_LIMIT):
                o_select = 4'b1000;
            default:
                o_select = 4'b0000;
        endcase
        o_unmapped = (o_select == 4'b0000);
    end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller, 32-bit transfers only.
// Define BRIDGE_ERR_RESP_EN for a two-cycle ERROR on unmapped addresses.
module apb_bridge_ctrl
    import bridge_pkg::*;
(
    input  logic               clk,
    input  logic               hreset,
    apb_bridge_ctrl_if.slave   bus
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_haddr;
    logic [31:0] r_pwdata;
    logic        r_hwrite;
    logic [3:0]  r_sel;

    logic [3:0]  w_sel;
    logic        w_unmapped;
    logic        w_valid;
    logic        w_accept;
    logic        w_hready;
    logic [1:0]  w_resp;
    logic [3:0]  w_psel;
    logic        w_pen;
    logic        w_unused;

    // all transfers are 32-bit, so hsize carries no information
    assign w_unused = ^bus.hsize;

    apb_bridge_decode u_decode (
        .i_haddr    (bus.haddr),
        .o_select   (w_sel),
        .o_unmapped (w_unmapped)
    );

    // hreadyout is 1 in both accepting states, so it need not enter here
    assign w_valid = bus.hreadyin &&
                     (bus.htrans == HTRANS_NONSEQ ||
                      bus.htrans == HTRANS_SEQ);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_hready = 1'b1;
        w_resp   = HRESP_OKAY;
        w_psel   = 4'b0000;
        w_pen    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = w_valid;
            end
            ST_WWAIT: begin
                w_hready = 1'b0;
                w_next   = ST_SETUP;
            end
            ST_SETUP: begin
                w_hready = 1'b0;
                w_psel   = r_sel;
                w_next   = ST_ENABLE;
            end
            ST_ENABLE: begin
                w_psel   = r_sel;
                w_pen    = 1'b1;
                w_accept = w_valid;
                w_next   = ST_IDLE;
            end
`ifdef BRIDGE_ERR_RESP_EN
            ST_ERR1: begin
                w_hready = 1'b0;
                w_resp   = HRESP_ERROR;
                w_next   = ST_ERR2;
            end
            ST_ERR2: begin
                w_resp   = HRESP_ERROR;
                w_next   = ST_IDLE;
            end
`endif
            default: begin
                w_next   = ST_IDLE;
            end
        endcase
        if (w_accept) begin
            if (w_unmapped) begin
`ifdef BRIDGE_ERR_RESP_EN
                w_next = ST_ERR1;
`else
                w_next = ST_IDLE;
`endif
            end else if (bus.hwrite) begin
                w_next = ST_WWAIT;
            end else begin
                w_next = ST_SETUP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_haddr  <= 32'h0;
            r_pwdata <= 32'h0;
            r_hwrite <= 1'b0;
            r_sel    <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_haddr  <= bus.haddr;
                r_hwrite <= bus.hwrite;
                r_sel    <= w_sel;
            end
            // write data arrives in the AHB data phase
            if (r_state == ST_WWAIT) begin
                r_pwdata <= bus.hwdata;
            end
        end
    end

    assign bus.pselx     = w_psel;
    assign bus.penable   = w_pen;
    assign bus.pwrite    = r_hwrite;
    assign bus.paddr     = r_haddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.hreadyout = w_hready;
    assign bus.hresp     = w_resp;
    assign bus.hrdata    = (r_state == ST_ENABLE && !r_hwrite) ?
                           bus.prdata : 32'h0;

endmodule
